// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// The privilege-check option is selected by the macro IMEM_RESPONDER_PRIV_CHECK_EN.
package imem_pkg;

    typedef enum logic [1:0] {
        HPL_U = 2'b00,
        HPL_S = 2'b01,
        HPL_M = 2'b11
    } hpl_t;

    typedef struct packed {
        logic        rerr;
        logic [31:0] data;
    } rsp_t;

    localparam int unsigned C_INS_BYTES = 4;

    // An errored response never carries SRAM data.
    function automatic rsp_t make_rsp(input logic err, input logic [31:0] rdata);
        rsp_t r;
        r.rerr = err;
        r.data = err ? 32'h0 : rdata;
        return r;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO of rsp_t, depth 2**C_DEPTH_X, with clock enable and async reset.
// Part of imem_responder (option macro IMEM_RESPONDER_PRIV_CHECK_EN does not affect this file).
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int unsigned C_DEPTH_X = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clk_en_i,
    input  logic               push_i,
    input  rsp_t               push_data_i,
    input  logic               pop_i,
    output rsp_t               head_o,
    output logic               empty_o,
    output logic [C_DEPTH_X:0] count_o
);

    localparam int unsigned D  = 1 << C_DEPTH_X;
    localparam int unsigned PW = (C_DEPTH_X > 0) ? C_DEPTH_X : 1;

    rsp_t               mem_q [D];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [C_DEPTH_X:0] count_q, count_d;
    logic               do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & clk_en_i;
    assign do_pop  = pop_i & clk_en_i & ~empty_o;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the occupancy count alone says which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-port responder: credit-gated fetch acceptance, one-cycle SRAM read stage, in-order response FIFO.
// Define IMEM_RESPONDER_PRIV_CHECK_EN to reject fetches from harts below C_MIN_HPL.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned C_FIFO_DEPTH_X = 2,
    parameter int unsigned C_MEM_ADDR_SZ  = 12,
    parameter logic [31:0] C_MEM_BASE     = 32'h00000000,
    parameter logic [1:0]  C_MIN_HPL      = 2'b00
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clk_en_i,
    output logic                     ireqready_o,
    input  logic                     ireqvalid_i,
    input  logic [1:0]               ireqhpl_i,
    input  logic [31:0]              ireqaddr_i,
    input  logic                     irspready_i,
    output logic                     irspvalid_o,
    output logic                     irsprerr_o,
    output logic [31:0]              irspdata_o,
    output logic                     mem_en_o,
    output logic [C_MEM_ADDR_SZ-1:0] mem_addr_o,
    input  logic [31:0]              mem_rdata_i
);

    localparam int unsigned D  = 1 << C_FIFO_DEPTH_X;
    localparam int unsigned CW = C_FIFO_DEPTH_X + 2;

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_err_q, s1_err_d;
    logic                    accept, req_err, in_window;
    logic [31:0]             win_offset;
    logic [CW-1:0]           in_flight;
    logic [C_FIFO_DEPTH_X:0] fifo_count;
    logic                    fifo_empty, fifo_pop;
    rsp_t                    fifo_head;

    // Credits count both buffered responses and the read still in the SRAM stage.
    assign in_flight   = CW'(fifo_count) + CW'(s1_valid_q);
    assign ireqready_o = (in_flight < CW'(D));
    assign accept      = ireqvalid_i & ireqready_o & clk_en_i;

    assign win_offset = ireqaddr_i - C_MEM_BASE;
    assign in_window  = (ireqaddr_i >= C_MEM_BASE)
                      && ((33'(win_offset) >> C_MEM_ADDR_SZ) < 33'(C_INS_BYTES));

`ifdef IMEM_RESPONDER_PRIV_CHECK_EN
    assign req_err = (ireqaddr_i[1:0] != 2'b00) | ~in_window | (ireqhpl_i < C_MIN_HPL);
`else
    logic unused_hpl;
    assign unused_hpl = ^{ireqhpl_i, C_MIN_HPL};
    assign req_err    = (ireqaddr_i[1:0] != 2'b00) | ~in_window;
`endif

    assign mem_en_o   = accept & ~req_err;
    assign mem_addr_o = ireqaddr_i[C_MEM_ADDR_SZ+1:2];

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_err_d   = s1_err_q;
        if (clk_en_i) begin
            s1_valid_d = accept;
            s1_err_d   = req_err;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
        end
    end

    assign fifo_pop = irspvalid_o & irspready_i;

    imem_rsp_fifo #(
        .C_DEPTH_X (C_FIFO_DEPTH_X)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clk_en_i    (clk_en_i),
        .push_i      (s1_valid_q),
        .push_data_i (make_rsp(s1_err_q, mem_rdata_i)),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Unwritten FIFO slots are never exposed: outputs read as zero while empty.
    assign irspvalid_o = ~fifo_empty;
    assign irsprerr_o  = irspvalid_o & fifo_head.rerr;
    assign irspdata_o  = irspvalid_o ? fifo_head.data : 32'h0;

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder with a registered-read SRAM model and in-order scoreboard.
module tb_imem_responder;
    import imem_pkg::*;

`ifdef IMEM_RESPONDER_PRIV_CHECK_EN
    localparam logic [1:0] MIN_HPL = 2'b11;
`else
    localparam logic [1:0] MIN_HPL = 2'b00;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        clk_en_i = 1'b1;
    logic        ireqready_o;
    logic        ireqvalid_i = 1'b0;
    logic [1:0]  ireqhpl_i = HPL_M;
    logic [31:0] ireqaddr_i = 32'h0;
    logic        irspready_i = 1'b0;
    logic        irspvalid_o;
    logic        irsprerr_o;
    logic [31:0] irspdata_o;
    logic        mem_en_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_rdata_i = 32'h0;

    logic [31:0] sram [4096];
    logic [32:0] exp_q [$];
    int total = 0, bad = 0, n_rsp = 0, cyc = 0;
    int first_v = -1, last_v = -1, vcnt = 0, acc = 0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (mem_en_o) mem_rdata_i <= sram[mem_addr_o];

    imem_responder #(
        .C_FIFO_DEPTH_X (2),
        .C_MEM_ADDR_SZ  (12),
        .C_MEM_BASE     (32'h00000000),
        .C_MIN_HPL      (MIN_HPL)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clk_en_i    (clk_en_i),
        .ireqready_o (ireqready_o),
        .ireqvalid_i (ireqvalid_i),
        .ireqhpl_i   (ireqhpl_i),
        .ireqaddr_i  (ireqaddr_i),
        .irspready_i (irspready_i),
        .irspvalid_o (irspvalid_o),
        .irsprerr_o  (irsprerr_o),
        .irspdata_o  (irspdata_o),
        .mem_en_o    (mem_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] addr, input logic [1:0] hpl);
        logic err;
        err = (addr[1:0] != 2'b00) || (addr >= 32'h00004000) || (hpl < MIN_HPL);
        return err ? {1'b1, 32'h0} : {1'b0, sram[addr[13:2]]};
    endfunction

    // One clock: record handshakes at the current inputs, then move to 1 time unit past the next edge.
    task automatic tick();
        if (ireqvalid_i && ireqready_o && clk_en_i) exp_q.push_back(model(ireqaddr_i, ireqhpl_i));
        if (irspvalid_o) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            vcnt++;
        end
        if (irspvalid_o && irspready_i && clk_en_i) begin
            if (exp_q.size() == 0) begin
                check("stray_rsp", {31'h0, irspvalid_o}, 33'h0);
            end else begin
                check("rsp_order", {irsprerr_o, irspdata_o}, exp_q[0]);
                void'(exp_q.pop_front());
            end
            n_rsp++;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic single_fetch(input string tag, input logic [31:0] addr, input logic [1:0] hpl,
                                input logic exp_en, input logic [32:0] exp_rsp);
        ireqvalid_i = 1'b1;
        ireqaddr_i  = addr;
        ireqhpl_i   = hpl;
        irspready_i = 1'b1;
        #1;
        check({tag, "_mem_en"}, {32'h0, mem_en_o}, {32'h0, exp_en});
        if (exp_en) check({tag, "_mem_addr"}, {21'h0, mem_addr_o}, {21'h0, addr[13:2]});
        tick();
        ireqvalid_i = 1'b0;
        ireqhpl_i   = HPL_M;
        #1;
        check({tag, "_valid_n1"}, {32'h0, irspvalid_o}, 33'h0);
        tick();
        check({tag, "_valid_n2"}, {32'h0, irspvalid_o}, 33'h1);
        check({tag, "_rsp_n2"}, {irsprerr_o, irspdata_o}, exp_rsp);
        tick();
        check({tag, "_valid_n3"}, {32'h0, irspvalid_o}, 33'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = 32'h10000000 + i;
        sram[4] = 32'h00000013;

        // Reset state
        #12;
        check("rst_ready", {32'h0, ireqready_o}, 33'h1);
        check("rst_valid", {32'h0, irspvalid_o}, 33'h0);
        check("rst_rsp", {irsprerr_o, irspdata_o}, 33'h0);
        check("rst_mem_en", {32'h0, mem_en_o}, 33'h0);
        @(negedge clk_i);
        reset_i = 1'b0;
        tick();

        // Single aligned fetch, misaligned fetch, out-of-window fetch
        single_fetch("fetch10", 32'h00000010, HPL_M, 1'b1, {1'b0, 32'h00000013});
        single_fetch("misalign", 32'h00000006, HPL_M, 1'b0, {1'b1, 32'h0});
        single_fetch("oow", 32'h00004000, HPL_M, 1'b0, {1'b1, 32'h0});
        single_fetch("last_word", 32'h00003FFC, HPL_M, 1'b1, {1'b0, 32'h10000FFF});

`ifdef IMEM_RESPONDER_PRIV_CHECK_EN
        single_fetch("hpl_u", 32'h00000010, HPL_U, 1'b0, {1'b1, 32'h0});
        single_fetch("hpl_m", 32'h00000010, HPL_M, 1'b1, {1'b0, 32'h00000013});
`endif

        // Back-pressure: four credits, then drain and finish the remaining two
        irspready_i = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            ireqvalid_i = 1'b1;
            ireqaddr_i  = 32'h50 + 32'(acc) * 4;
            #1;
            if (ireqready_o) acc++;
            tick();
        end
        ireqaddr_i = 32'h50 + 32'(acc) * 4;
        #1;
        check("bp_accepted", 33'(acc), 33'd4);
        check("bp_ready_low", {32'h0, ireqready_o}, 33'h0);
        check("bp_head_hold", {irsprerr_o, irspdata_o}, {1'b0, 32'h10000014});
        n_rsp = 0;
        irspready_i = 1'b1;
        for (int i = 0; i < 40 && (n_rsp < 6 || acc < 6); i++) begin
            ireqaddr_i = 32'h50 + 32'(acc) * 4;
            ireqvalid_i = (acc < 6);
            #1;
            if (ireqvalid_i && ireqready_o) acc++;
            tick();
        end
        ireqvalid_i = 1'b0;
        check("bp_total_acc", 33'(acc), 33'd6);
        check("bp_total_rsp", 33'(n_rsp), 33'd6);

        // Streaming: 16 back-to-back fetches must produce 16 back-to-back responses
        first_v = -1; last_v = -1; vcnt = 0; n_rsp = 0;
        for (int i = 0; i < 16; i++) begin
            ireqvalid_i = 1'b1;
            ireqaddr_i  = 32'(i) * 4;
            #1;
            if (!ireqready_o) check("stream_ready", {32'h0, ireqready_o}, 33'h1);
            tick();
        end
        ireqvalid_i = 1'b0;
        for (int i = 0; i < 20 && n_rsp < 16; i++) tick();
        check("stream_rsp", 33'(n_rsp), 33'd16);
        check("stream_vcnt", 33'(vcnt), 33'd16);
        check("stream_span", 33'(last_v - first_v + 1), 33'd16);

        // Clock enable low: no handshake, no SRAM access, held response
        irspready_i = 1'b0;
        ireqvalid_i = 1'b1;
        ireqaddr_i  = 32'h20;
        clk_en_i    = 1'b0;
        #1;
        check("cke_mem_en", {32'h0, mem_en_o}, 33'h0);
        tick(); tick(); tick();
        check("cke_no_rsp", {32'h0, irspvalid_o}, 33'h0);
        clk_en_i = 1'b1;
        #1;
        check("cke_mem_en_on", {32'h0, mem_en_o}, 33'h1);
        tick();
        ireqvalid_i = 1'b0;
        tick();
        check("cke_rsp", {irsprerr_o, irspdata_o}, {1'b0, 32'h10000008});
        clk_en_i    = 1'b0;
        irspready_i = 1'b1;
        tick(); tick();
        check("cke_hold_valid", {32'h0, irspvalid_o}, 33'h1);
        check("cke_hold_rsp", {irsprerr_o, irspdata_o}, {1'b0, 32'h10000008});
        clk_en_i = 1'b1;
        tick();
        check("cke_popped", {32'h0, irspvalid_o}, 33'h0);

        // Asynchronous reset with three outstanding requests
        irspready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ireqvalid_i = 1'b1;
            ireqaddr_i  = 32'h30 + 32'(i) * 4;
            tick();
        end
        ireqvalid_i = 1'b0;
        tick(); tick();
        check("mid_valid", {32'h0, irspvalid_o}, 33'h1);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_valid", {32'h0, irspvalid_o}, 33'h0);
        check("arst_ready", {32'h0, ireqready_o}, 33'h1);
        check("arst_rsp", {irsprerr_o, irspdata_o}, 33'h0);
        exp_q.delete();
        @(negedge clk_i);
        reset_i = 1'b0;
        irspready_i = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) tick();
        check("post_rst_valid", {32'h0, irspvalid_o}, 33'h0);
        check("post_rst_ready", {32'h0, ireqready_o}, 33'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
